// File: rtl/sin_cos_phase_detect.sv
// Iterative vectoring-mode CORDIC: signed sin/cos pair in, phase (turns, 2^WIDTH per circle) and magnitude out.
// Define MAG_COMP_EN to add one clock that scales the magnitude by 1/K so mag ~ sqrt(sin^2+cos^2).
module sin_cos_phase_detect #(
    parameter int WIDTH = 24,
    parameter int ITER  = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sin,
    input  logic [WIDTH-1:0] cos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] phase,
    output logic [WIDTH:0]   mag
);
    localparam int XW = WIDTH + 2;
    localparam int CW = $clog2(ITER + 1);
    localparam int SH = 32 - WIDTH;

    // atan(2^-i) in 2^32-per-turn units; narrowed with rounding to WIDTH bits
    localparam logic [31:0] ATAN32 [32] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

    function automatic logic [WIDTH-1:0] atan_lut(input logic [4:0] i);
        logic [32:0] r;
        r = ({1'b0, ATAN32[i]} + ((33'd1 << SH) >> 1)) >> SH;
        return r[WIDTH-1:0];
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        ROT,
`ifdef MAG_COMP_EN
        COMP,
`endif
        DONE
    } state_t;

    state_t                 state, state_nxt;
    logic signed [XW-1:0]   x, y, x_nxt, y_nxt, dx, dy, cos_x, sin_x;
    logic [WIDTH-1:0]       z, z_nxt, at;
    logic [CW-1:0]          cnt;
    logic                   zero;
    logic                   accept, last;

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == CW'(ITER - 1));
    assign cos_x     = {{2{cos[WIDTH-1]}}, cos};
    assign sin_x     = {{2{sin[WIDTH-1]}}, sin};

    // one micro-rotation steering y toward zero; x only ever grows
    always_comb begin
        dx = x >>> cnt;
        dy = y >>> cnt;
        at = atan_lut(5'(cnt));
        if (y[XW-1]) begin
            x_nxt = x - dy;
            y_nxt = y + dx;
            z_nxt = z - at;
        end else begin
            x_nxt = x + dy;
            y_nxt = y - dx;
            z_nxt = z + at;
        end
    end

`ifdef MAG_COMP_EN
    localparam logic [16:0] KMAG = 17'd39797;
    logic [XW+16:0] prod;
    logic [WIDTH:0] mag_c;
    assign prod  = {17'b0, x} * {{XW{1'b0}}, KMAG};
    assign mag_c = (WIDTH+1)'(prod >> 16);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = ROT;
`ifdef MAG_COMP_EN
            ROT:  if (last) state_nxt = COMP;
            COMP: state_nxt = DONE;
`else
            ROT:  if (last) state_nxt = DONE;
`endif
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x     <= '0;
            y     <= '0;
            z     <= '0;
            cnt   <= '0;
            zero  <= 1'b0;
            phase <= '0;
            mag   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    zero <= (sin == '0) && (cos == '0);
                    cnt  <= '0;
                    // left half-plane: rotate by pi so CORDIC only sees x >= 0
                    if (cos[WIDTH-1]) begin
                        x <= -cos_x;
                        y <= -sin_x;
                        z <= {1'b1, {(WIDTH-1){1'b0}}};
                    end else begin
                        x <= cos_x;
                        y <= sin_x;
                        z <= '0;
                    end
                end
                ROT: begin
                    x   <= x_nxt;
                    y   <= y_nxt;
                    z   <= z_nxt;
                    cnt <= cnt + CW'(1);
`ifndef MAG_COMP_EN
                    if (last) begin
                        phase <= zero ? '0 : z_nxt;
                        mag   <= zero ? '0 : x_nxt[WIDTH:0];
                    end
`endif
                end
`ifdef MAG_COMP_EN
                COMP: begin
                    phase <= zero ? '0 : z;
                    mag   <= zero ? '0 : mag_c;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sin_cos_phase_detect.sv
// Self-checking bench for sin_cos_phase_detect: directed table, handshake/reset corners, random vs atan2/sqrt model.
module tb_sin_cos_phase_detect;
    localparam int  W      = 24;
    localparam int  IT     = 20;
    localparam real PI     = 3.14159265358979323846;
    localparam int  TOL_PH = 18;
`ifdef MAG_COMP_EN
    localparam int  LAT  = IT + 2;
    localparam real GAIN = 1.0;
`else
    localparam int  LAT  = IT + 1;
    localparam real GAIN = 1.6467602581;
`endif

    logic          clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic          in_ready, out_valid;
    logic [W-1:0]  sin_s = '0, cos_s = '0;
    logic [W-1:0]  phase;
    logic [W:0]    mag;
    int            checks = 0, errors = 0;

    sin_cos_phase_detect #(.WIDTH(W), .ITER(IT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sin(sin_s), .cos(cos_s), .out_valid(out_valid), .out_ready(out_ready),
        .phase(phase), .mag(mag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int  s;
        int  c;
        int  ph;
        real tmag;
    } vec_t;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pdiff(input int a, input int e);
        int d;
        d = (a - e) & 32'h00FF_FFFF;
        if (d >= (1 << (W - 1))) d -= (1 << W);
        return d;
    endfunction

    function automatic int ref_phase(input int s, input int c);
        real a;
        a = $atan2(real'(s), real'(c)) / (2.0 * PI) * 16777216.0;
        if (a < 0.0) a += 16777216.0;
        return int'(a) % (1 << W);
    endfunction

    task automatic check_result(input string tag, input int eph, input real tmag,
                                input int ph, input int mg, input int lat);
        int d, emg, tol;
        if (lat < 0) return;
        chk(lat == LAT, {tag, " latency"}, lat, LAT);
        if (tmag == 0.0) begin
            chk(ph == 0, {tag, " zero phase"}, ph, 0);
            chk(mg == 0, {tag, " zero mag"}, mg, 0);
            return;
        end
        d = pdiff(ph, eph);
        chk(d >= -TOL_PH && d <= TOL_PH, {tag, " phase"}, ph, eph);
        emg = int'(tmag * GAIN);
        tol = int'(tmag * GAIN * 0.001) + 4;
        chk(mg >= emg - tol && mg <= emg + tol, {tag, " mag"}, mg, emg);
    endtask

    // wait (bounded) for out_valid; lat counts clocks from the accept cycle
    task automatic wait_result(input string tag, output int ph, output int mg, inout int lat);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            chk(1'b0, {tag, " result timeout"}, lat, LAT);
            lat = -1;
            ph  = -1;
            mg  = -1;
            return;
        end
        ph = int'(phase);
        mg = int'(mag);
    endtask

    task automatic xact(input string tag, input int s, input int c,
                        output int ph, output int mg, output int lat);
        int n;
        ph = -1; mg = -1; lat = -1;
        @(negedge clk);
        sin_s = W'(s); cos_s = W'(c); in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk(1'b0, {tag, " accept timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        wait_result(tag, ph, mg, lat);
        if (lat < 0) return;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk(!out_valid, {tag, " out_valid drop"}, out_valid, 0);
    endtask

    vec_t vt[8];

    initial begin
        int ph, mg, lat, ph0, mg0, prev, d, s, c, n;
        bit stable;
        logic [W-1:0] rs, rc;
        real r, ang;

        vt[0] = '{0,        4000000,  0,        4000000.0};
        vt[1] = '{4000000,  0,        4194304,  4000000.0};
        vt[2] = '{0,        -4000000, 8388608,  4000000.0};
        vt[3] = '{-4000000, 0,        12582912, 4000000.0};
        vt[4] = '{3000000,  3000000,  2097152,  4242640.687};
        vt[5] = '{0,        0,        0,        0.0};
        vt[6] = '{0,        -8388608, 8388608,  8388608.0};
        vt[7] = '{-3000000, 3000000,  14680064, 4242640.687};

        // reset state
        repeat (3) @(negedge clk);
        chk(!in_ready,  "reset in_ready",  in_ready, 0);
        chk(!out_valid, "reset out_valid", out_valid, 0);
        chk(phase == 0, "reset phase", phase, 0);
        chk(mag == 0,   "reset mag", mag, 0);
        reset = 1'b0;
        @(negedge clk);
        chk(in_ready, "post-reset in_ready", in_ready, 1);

        // directed table
        foreach (vt[i]) begin
            xact($sformatf("vec%0d", i), vt[i].s, vt[i].c, ph, mg, lat);
            check_result($sformatf("vec%0d", i), vt[i].ph, vt[i].tmag, ph, mg, lat);
        end

        // back-pressure: DONE holds, busy input not consumed
        @(negedge clk);
        sin_s = W'(4000000); cos_s = '0; in_valid = 1'b1;
        chk(in_ready, "hold accept ready", in_ready, 1);
        @(negedge clk);
        sin_s = '0; cos_s = W'(-4000000);
        lat = 1;
        wait_result("hold first", ph0, mg0, lat);
        check_result("hold first", 4194304, 4000000.0, ph0, mg0, lat);
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!out_valid || int'(phase) != ph0 || int'(mag) != mg0 || in_ready) stable = 1'b0;
        end
        chk(stable, "hold stable", stable, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk(in_ready, "hold release ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        wait_result("hold second", ph, mg, lat);
        check_result("hold second", 8388608, 4000000.0, ph, mg, lat);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // reset mid-rotation aborts the sample
        @(negedge clk);
        sin_s = W'(2500000); cos_s = W'(-1500000); in_valid = 1'b1;
        chk(in_ready, "abort accept ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk(!out_valid, "abort out_valid", out_valid, 0);
        chk(phase == 0, "abort phase", phase, 0);
        chk(mag == 0,   "abort mag", mag, 0);
        chk(!in_ready,  "abort in_ready", in_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk(in_ready, "abort recover ready", in_ready, 1);
        xact("after abort", -2000000, 3500000, ph, mg, lat);
        check_result("after abort", ref_phase(-2000000, 3500000),
                     $sqrt(4.0e12 + 12.25e12), ph, mg, lat);

        // loopback-style sweep with a constant phase step
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            ang = 2.0 * PI * real'(k * 2100003 % (1 << W)) / 16777216.0;
            s = int'(4000000.0 * $sin(ang));
            c = int'(4000000.0 * $cos(ang));
            xact($sformatf("sweep%0d", k), s, c, ph, mg, lat);
            if (k > 0 && lat >= 0) begin
                d = pdiff(ph, prev);
                chk(d >= 2100003 - TOL_PH && d <= 2100003 + TOL_PH,
                    $sformatf("sweep%0d step", k), d, 2100003);
            end
            prev = ph;
        end

        // random vectors against atan2/sqrt model
        n = 0;
        while (n < 30) begin
            rs = W'($urandom);
            rc = W'($urandom);
            s = int'($signed(rs));
            c = int'($signed(rc));
            r = $sqrt(real'(s) * real'(s) + real'(c) * real'(c));
            if (r >= 4194304.0) begin
                xact($sformatf("rand%0d", n), s, c, ph, mg, lat);
                check_result($sformatf("rand%0d s=%0d c=%0d", n, s, c),
                             ref_phase(s, c), r, ph, mg, lat);
                n++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
